// File: rtl/serial_bit_tx.sv
// serial_bit_tx
//   Parallel-to-serial transmitter, MSB first, one bit per clock. Frames can
//   run back-to-back with no gap bit. Transmission can be frozen with stall.
//   zero_count reports how many 0 bits the current frame has driven so far.
//
// Parameters
//   WIDTH     frame length in bits (>= 2)
//   IDLE_BIT  line level on x_out while no frame is active
//   CW        width of zero_count, $clog2(WIDTH+1)
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high
//   data_in     frame word, sampled only when a load is accepted
//   load        load request
//   stall       freezes shifting while a frame is active
//   x_out       registered serial bit
//   ready       a load presented now is accepted at the next rising edge
//   busy        a frame bit is on x_out (state == SHIFT)
//   done        one-cycle pulse in the first cycle the last bit is on x_out
//   zero_count  registered count of 0 bits driven in the current frame
//
// Handshake: a load is accepted on a rising edge where load=1 and ready=1,
// and data_in is sampled on that same edge. While ready=0, load and data_in
// are ignored. ready depends combinationally on stall, so a stalled last bit
// refuses a load.
module serial_bit_tx #(
  parameter int WIDTH    = 8,
  parameter bit IDLE_BIT = 1'b1,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             stall,
  output logic             x_out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    zero_count
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] PEN  = IW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  // The MSB goes straight into x_out on load. This register keeps the
  // remaining WIDTH-1 bits, and the next bit to send sits at the top.
  logic [WIDTH-2:0] rest;

  logic accept;

  assign ready  = (state == IDLE) || ((state == SHIFT) && (idx == LAST) && !stall);
  assign busy   = (state == SHIFT);
  assign accept = load && ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      rest       <= '0;
      x_out      <= IDLE_BIT;
      done       <= 1'b0;
      zero_count <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Frame start. This covers both IDLE and a back-to-back reload on the last bit.
        state      <= SHIFT;
        rest       <= data_in[WIDTH-2:0];
        x_out      <= data_in[WIDTH-1];
        idx        <= '0;
        zero_count <= data_in[WIDTH-1] ? CW'(0) : CW'(1);
      end else if ((state == SHIFT) && !stall) begin
        if (idx == LAST) begin
          // Frame complete with no follow-on load. zero_count keeps the frame total.
          state <= IDLE;
          x_out <= IDLE_BIT;
        end else begin
          rest  <= rest << 1;
          x_out <= rest[WIDTH-2];
          idx   <= idx + IW'(1);
          if (!rest[WIDTH-2]) begin
            zero_count <= zero_count + CW'(1);
          end
          if (idx == PEN) begin
            done <= 1'b1;
          end
        end
      end else if (state == IDLE) begin
        x_out <= IDLE_BIT;
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx (WIDTH=8, IDLE_BIT=1).
// The driver pushes the hand-computed per-cycle output of each frame into a
// queue of {ready, x_out, done, zero_count}. The monitor runs on the falling
// edge. It pops one entry for every cycle busy is high. On idle cycles it
// checks that the line sits at the idle level with ready=1 and done=0.
module tb_serial_bit_tx;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int EW    = 3 + CW;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             stall;
  logic             x_out;
  logic             ready;
  logic             busy;
  logic             done;
  logic [CW-1:0]    zero_count;

  logic [EW-1:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  serial_bit_tx #(.WIDTH(WIDTH), .IDLE_BIT(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .stall      (stall),
    .x_out      (x_out),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .zero_count (zero_count)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic r, input logic x, input logic d, input logic [CW-1:0] zc);
    exp_q.push_back({r, x, d, zc});
  endtask

  // Push one unstalled frame. bits is the hand-written line sequence (MSB first).
  // zcs holds eight hand-written zero_count nibbles, cycle 1 in the top nibble.
  task automatic push_frame(input logic [7:0] bits, input logic [31:0] zcs);
    for (int i = 0; i < 8; i++) begin
      push(i == 7, bits[7-i], i == 7, zcs[31-4*i -: 4]);
    end
  endtask

  // Hold load for one edge with data d, then drop it. Returns in cycle 1 of the frame.
  task automatic start_load(input logic [7:0] d);
    load    = 1'b1;
    data_in = d;
    tick();
    load    = 1'b0;
    data_in = 8'h5A;
  endtask

  task automatic check_idle(input string name, input logic [CW-1:0] zc);
    check({name, "_x"}, {31'd0, x_out}, 32'd1);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_ready"}, {31'd0, ready}, 32'd1);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_zc"}, {28'd0, zero_count}, {28'd0, zc});
  endtask

  // Monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clock);
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_busy: got busy=1 with x=%0b zc=%0d, expected no frame bit at %0t",
                   x_out, zero_count, $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_cycle", {25'd0, ready, x_out, done, zero_count}, {25'd0, e});
        end
      end else begin
        check("idle_line", {29'd0, ready, x_out, done}, 32'b110);
      end
    end
  end

  // Stimulus
  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    stall   = 1'b0;
    data_in = '0;
    // Reset is applied before any clock edge, so these values come from the asynchronous path alone.
    #3;
    check_idle("reset_async", 4'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single frame B2 = 1011_0010
    push_frame(8'b1011_0010, 32'h0111_2334);
    start_load(8'hB2);
    repeat (8) tick();
    check_idle("single_after", 4'd4);

    // Back-to-back A5 then 00
    push_frame(8'b1010_0101, 32'h0112_3344);
    push_frame(8'b0000_0000, 32'h1234_5678);
    start_load(8'hA5);
    repeat (7) tick();
    load    = 1'b1;
    data_in = 8'h00;
    tick();
    load    = 1'b0;
    repeat (8) tick();
    check_idle("b2b_after", 4'd8);

    // Stall F0: third bit held for 4 cycles. A load during the stall is ignored.
    for (int i = 0; i < 7; i++) push(1'b0, 1'b1, 1'b0, 4'd0);
    push(1'b0, 1'b0, 1'b0, 4'd1);
    push(1'b0, 1'b0, 1'b0, 4'd2);
    push(1'b0, 1'b0, 1'b0, 4'd3);
    push(1'b1, 1'b0, 1'b1, 4'd4);
    start_load(8'hF0);
    tick();
    tick();
    stall = 1'b1;
    tick();
    load    = 1'b1;
    data_in = 8'h00;
    tick();
    load = 1'b0;
    tick();
    stall = 1'b0;
    repeat (6) tick();
    check_idle("stall_after", 4'd4);

    // Stall on the last bit of 81 with load held. The load is refused and done does not re-pulse.
    push(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i < 7; i++) push(1'b0, 1'b0, 1'b0, 4'(i));
    push(1'b0, 1'b1, 1'b1, 4'd6);
    push(1'b0, 1'b1, 1'b0, 4'd6);
    push(1'b1, 1'b1, 1'b0, 4'd6);
    start_load(8'h81);
    repeat (7) tick();
    stall   = 1'b1;
    load    = 1'b1;
    data_in = 8'h00;
    tick();
    tick();
    stall = 1'b0;
    load  = 1'b0;
    tick();
    check_idle("last_stall_after", 4'd6);

    // Ignored load mid-frame of FF
    push_frame(8'b1111_1111, 32'h0000_0000);
    start_load(8'hFF);
    repeat (3) tick();
    load    = 1'b1;
    data_in = 8'h00;
    tick();
    load = 1'b0;
    repeat (4) tick();
    check_idle("ignored_after", 4'd0);
    tick();

    // Reset in cycle 5 of a 0F frame, then a clean 0F frame.
    push(1'b0, 1'b0, 1'b0, 4'd1);
    push(1'b0, 1'b0, 1'b0, 4'd2);
    push(1'b0, 1'b0, 1'b0, 4'd3);
    push(1'b0, 1'b0, 1'b0, 4'd4);
    start_load(8'h0F);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check_idle("reset_mid", 4'd0);
    tick();
    tick();
    reset = 1'b0;
    push_frame(8'b0000_1111, 32'h1234_4444);
    start_load(8'h0F);
    repeat (8) tick();
    check_idle("reload_after", 4'd4);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_bit_tx.md
# serial_bit_tx

Parallel-to-serial bit-stream transmitter, MSB first, one bit per clock, with a load/ready handshake. It generates the single-bit serial stimulus that the lab's sequence-detector FSMs consume, e.g. the `x_in` input of the Mealy zero detector. It runs frames back-to-back with no gap, supports stalling, and reports the number of zero bits sent in the current frame.

## Interface
- `WIDTH`, default 8: frame length in bits; must be ≥ 2.
- `IDLE_BIT`, default 1: line level driven on `x_out` when no frame is active.
- `CW`, derived as $clog2(WIDTH+1): width of `zero_count`.

- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces every output to its reset value immediately.
- `data_in`  in  WIDTH  frame word; sampled only on an accepted load.
- `load`  in  1  load request; accepted at a rising edge only when `ready`=1.
- `stall`  in  1  freezes transmission while in SHIFT; ignored in IDLE.
- `x_out`  out  1  serial output bit; registered.
- `ready`  out  1  block can accept `load` at the next edge.
- `busy`  out  1  a frame bit is on `x_out`.
- `done`  out  1  single-cycle pulse on the first cycle the last frame bit is on `x_out`.
- `zero_count`  out  CW  count of 0 bits driven so far in the current frame; registered.

## Operation
- State machine has two states, IDLE and SHIFT. It holds a WIDTH-bit shift register and a bit index `idx` in the range 0..WIDTH-1.
- Reset values: state=IDLE, `x_out`=IDLE_BIT, `ready`=1, `busy`=0, `done`=0, `zero_count`=0, shift register=0.
- IDLE:
  - `x_out`=IDLE_BIT, `busy`=0, `ready`=1.
  - On an edge with `load`=1: capture `data_in`, drive `x_out`←`data_in[WIDTH-1]`, set `idx`=0, set `zero_count` to 1 if that bit is 0 and to 0 otherwise, then go to SHIFT.
- SHIFT, `stall`=0, `idx`<WIDTH-1: at the edge, `x_out`←next bit (MSB-first order), `idx`+1, and `zero_count` increments if the new bit is 0.
- SHIFT, `idx`=WIDTH-1 (last bit on the line): `ready`=`~stall`. At the edge:
  - `load`=1 and `stall`=0: start a new frame exactly as in IDLE and stay in SHIFT, so there is no gap bit.
  - `load`=0 and `stall`=0: go to IDLE, `x_out`←IDLE_BIT, `zero_count` holds its final value.
  - `stall`=1: hold.
- `stall`=1 in SHIFT: no shift, `x_out`, `idx` and `zero_count` hold, `ready`=0, `load` is ignored.
- `load` while `ready`=0 is ignored; `data_in` is not sampled.
- `busy` = (state==SHIFT).
- `ready` = (state==IDLE) | (state==SHIFT & idx==WIDTH-1 & ~stall). This is combinational from state and `stall`.
- `done` is registered. It is set at the edge that places bit WIDTH-1 on the line and clears one cycle later, even if stalled.
- `zero_count` saturates naturally at WIDTH; no wrap is possible. It is cleared or reloaded only on a frame start or reset.
- Reset mid-frame: the frame is discarded. All outputs return to reset values asynchronously. The first `load` is accepted at the first rising edge after `reset` deasserts.

## Timing
- Latency: `load` accepted at edge k puts bit WIDTH-1 on `x_out` during cycle k+1. Bit i of the frame, counting from the MSB, is driven in cycle k+1+i plus the number of stall cycles before it.
- An unstalled frame occupies exactly WIDTH cycles on `x_out`.
- `done` and the last bit coincide in cycle k+WIDTH.
- Back-to-back: a load accepted in the last-bit cycle puts the new MSB on the line in the very next cycle.
- No combinational path from `data_in` to any output. `ready` depends on `stall` combinationally.

## Test plan
- Reset: assert `reset` asynchronously between edges → `x_out`=1, `ready`=1, `busy`=0, `done`=0, `zero_count`=0, all without waiting for a clock.
- Single frame, WIDTH=8, `data_in`=8'b1011_0010 loaded at edge 0 → `x_out` = 1,0,1,1,0,0,1,0 over cycles 1–8, with `zero_count` = 0,1,1,1,2,3,3,4. `done`=1 in cycle 8 only. Cycle 9 onward: `x_out`=1, `busy`=0, `zero_count`=4.
- Back-to-back: load 8'hA5, then load 8'h00 while the last bit is on the line → 16 contiguous bits 1010_0101_0000_0000. `done` pulses in cycles 8 and 16. `zero_count` reads 4 at cycle 8, then 1 at cycle 9, then 8 at cycle 16.
- Stall: load 8'hF0 and hold `stall`=1 for 3 cycles starting in cycle 3 → the third bit (1) is held for 4 cycles. The bit sequence is unchanged, the frame lasts 11 cycles, and `done` pulses once. A `load` during the stall is ignored.
- Ignored load: pulse `load` with `data_in`=8'h00 in cycle 4 of an 8'hFF frame → the output stays all ones, `zero_count`=0, and the block returns to IDLE after cycle 8.
- Reset mid-frame: assert `reset` in cycle 5 of an 8'h0F frame and release it 2 cycles later → `x_out`=1 and `busy`=0 immediately, no `done` pulse. A fresh load of 8'h0F then completes a full 8-bit frame correctly.
